// File: rtl/rv32_bus_pkg.sv
// Shared types for the priRV32 memory bus: arbiter states, requester ids and default widths.
package rv32_bus_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_IF,
    BUSY_LS
  } arb_state_t;

  typedef enum logic {
    REQ_IF,
    REQ_LS
  } req_id_t;

endpackage

// File: rtl/rv32_mem_arbiter_if.sv
// Bundles the fetch, load/store and memory-side signals of the arbiter.
// slave = arbiter view, master = core pipeline / memory view.
interface rv32_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic                  if_req;
  logic [ADDR_W-1:0]     if_addr;
  logic                  if_gnt;
  logic                  if_rvalid;
  logic [DATA_W-1:0]     if_rdata;

  logic                  ls_req;
  logic                  ls_we;
  logic [DATA_W/8-1:0]   ls_be;
  logic [ADDR_W-1:0]     ls_addr;
  logic [DATA_W-1:0]     ls_wdata;
  logic                  ls_gnt;
  logic                  ls_rvalid;
  logic [DATA_W-1:0]     ls_rdata;

  logic                  mem_req;
  logic                  mem_we;
  logic [DATA_W/8-1:0]   mem_be;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic                  mem_ready;
  logic [DATA_W-1:0]     mem_rdata;

  modport slave (
    input  if_req, if_addr,
    input  ls_req, ls_we, ls_be, ls_addr, ls_wdata,
    input  mem_ready, mem_rdata,
    output if_gnt, if_rvalid, if_rdata,
    output ls_gnt, ls_rvalid, ls_rdata,
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr,
    output ls_req, ls_we, ls_be, ls_addr, ls_wdata,
    output mem_ready, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata,
    input  ls_gnt, ls_rvalid, ls_rdata,
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata
  );

endinterface

// File: rtl/rv32_arb_starve_cnt.sv
// Saturating count of load/store grants taken while fetch waits; o_trip flags the limit.
module rv32_arb_starve_cnt #(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_trip
);

  localparam int CW = $clog2(MAX + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != MAX_C)) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_trip = (r_cnt == MAX_C);

endmodule

// File: rtl/rv32_mem_arbiter.sv
// Single-port memory arbiter: load/store over fetch, one transaction in flight.
// Define MEM_ARB_STARVE_GUARD_EN to bound fetch starvation to STARVE_MAX load/store grants.
module rv32_mem_arbiter
  import rv32_bus_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
`ifdef MEM_ARB_STARVE_GUARD_EN
  , parameter int STARVE_MAX = 4
`endif
) (
  input logic              clk,
  input logic              rst,
  rv32_mem_arbiter_if.slave bus
);

  localparam int BE_W = DATA_W / 8;

  arb_state_t          r_state;
  arb_state_t          w_next_state;
  logic                w_take_if;
  logic                w_take_ls;
  logic                w_grant_if;
  logic                w_grant_ls;
  logic                w_done_if;
  logic                w_done_ls;
  logic                w_guard_trip;

  logic                r_if_gnt;
  logic                r_ls_gnt;
  logic                r_if_rvalid;
  logic                r_ls_rvalid;
  logic [DATA_W-1:0]   r_if_rdata;
  logic [DATA_W-1:0]   r_ls_rdata;
  logic                r_mem_we;
  logic [BE_W-1:0]     r_mem_be;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;

`ifdef MEM_ARB_STARVE_GUARD_EN
  // Clearing also happens whenever fetch is idle, so the guard only counts a continuous wait.
  rv32_arb_starve_cnt #(
    .MAX (STARVE_MAX)
  ) u_starve_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_inc  (w_grant_ls && bus.if_req),
    .i_clr  (w_grant_if || ((r_state == IDLE) && !bus.if_req)),
    .o_trip (w_guard_trip)
  );
`else
  assign w_guard_trip = 1'b0;
`endif

  assign w_take_if = bus.if_req && (!bus.ls_req || w_guard_trip);
  assign w_take_ls = bus.ls_req && !w_take_if;

  always_comb begin
    w_next_state = r_state;
    w_grant_if   = 1'b0;
    w_grant_ls   = 1'b0;
    w_done_if    = 1'b0;
    w_done_ls    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_take_ls) begin
          w_next_state = BUSY_LS;
          w_grant_ls   = 1'b1;
        end else if (w_take_if) begin
          w_next_state = BUSY_IF;
          w_grant_if   = 1'b1;
        end
      end
      BUSY_IF: begin
        if (bus.mem_ready) begin
          w_next_state = IDLE;
          w_done_if    = 1'b1;
        end
      end
      BUSY_LS: begin
        if (bus.mem_ready) begin
          w_next_state = IDLE;
          w_done_ls    = 1'b1;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Transaction fields are captured only at grant so they stay stable while memory stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_if_gnt    <= 1'b0;
      r_ls_gnt    <= 1'b0;
      r_if_rvalid <= 1'b0;
      r_ls_rvalid <= 1'b0;
      r_if_rdata  <= '0;
      r_ls_rdata  <= '0;
      r_mem_we    <= 1'b0;
      r_mem_be    <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_state     <= w_next_state;
      r_if_gnt    <= w_grant_if;
      r_ls_gnt    <= w_grant_ls;
      r_if_rvalid <= w_done_if;
      r_ls_rvalid <= w_done_ls;
      r_if_rdata  <= w_done_if ? bus.mem_rdata : '0;
      r_ls_rdata  <= (w_done_ls && !r_mem_we) ? bus.mem_rdata : '0;
      if (w_grant_ls) begin
        r_mem_we    <= bus.ls_we;
        r_mem_be    <= bus.ls_be;
        r_mem_addr  <= bus.ls_addr;
        r_mem_wdata <= bus.ls_wdata;
      end else if (w_grant_if) begin
        r_mem_we    <= 1'b0;
        r_mem_be    <= '1;
        r_mem_addr  <= bus.if_addr;
        r_mem_wdata <= '0;
      end
    end
  end

  assign bus.mem_req   = (r_state != IDLE);
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_be    = r_mem_be;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.if_gnt    = r_if_gnt;
  assign bus.ls_gnt    = r_ls_gnt;
  assign bus.if_rvalid = r_if_rvalid;
  assign bus.ls_rvalid = r_ls_rvalid;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.ls_rdata  = r_ls_rdata;

endmodule

// File: doc/rv32_mem_arbiter.md
# rv32_mem_arbiter

Shares the single memory port of the priRV32 core between the instruction-fetch unit and the load/store unit. Accepts one request at a time, forwards it to memory with a req/ready handshake and returns read data or write completion to the winning requester. Load/store has priority over fetch; an optional starvation guard bounds fetch waiting time. Sits between the core pipeline and the on-chip memory/LED bus.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; byte-enable width is DATA_W/8
- STARVE_MAX, 4, consecutive load/store grants allowed while fetch waits (guard only)
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held with if_addr until if_gnt
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  one-cycle pulse: fetch request accepted
- if_rvalid  out  1  one-cycle pulse: if_rdata valid
- if_rdata  out  DATA_W  fetched word
- ls_req  in  1  load/store request; held with ls_* fields until ls_gnt
- ls_we  in  1  1 = store, 0 = load
- ls_be  in  DATA_W/8  byte enables
- ls_addr  in  ADDR_W  data address
- ls_wdata  in  DATA_W  store data
- ls_gnt  out  1  one-cycle pulse: load/store accepted
- ls_rvalid  out  1  one-cycle pulse: load data valid or store complete
- ls_rdata  out  DATA_W  load data (0 on store completion)
- mem_req  out  1  memory request, held until mem_ready
- mem_we, mem_be, mem_addr, mem_wdata  out  1/DATA_W/8/ADDR_W/DATA_W  registered transaction fields
- mem_ready  in  1  memory accepts/completes current request
- mem_rdata  in  DATA_W  read data, valid with mem_ready

## Operation
- FSM states: IDLE, BUSY_IF, BUSY_LS.
- IDLE: ls_req=1 (and guard not tripped) -> BUSY_LS; else if_req=1 -> BUSY_IF; else stay. mem_ready ignored in IDLE.
- On transition out of IDLE: latch selected fields into mem_*; fetch forces mem_we=0, mem_be=all ones; pulse matching gnt.
- BUSY_x: mem_req=1, fields stable; on mem_ready=1 -> IDLE, next cycle pulse x_rvalid with x_rdata = mem_rdata (stores: rdata 0).
- Requests presented while BUSY are not sampled; requester keeps req high until gnt.
- Simultaneous if_req and ls_req: ls wins unless guard tripped.
- Only one transaction outstanding; no buffering beyond the mem_* registers.
- Reset mid-transaction: returns to IDLE, mem_req drops, no rvalid produced; transaction is lost, requesters reissue.

## Timing
- Reset values: all outputs 0, state IDLE, guard counter 0.
- Req sampled in IDLE at cycle N -> gnt and mem_req high at N+1.
- mem_ready high at cycle M (M>=N+1) -> rvalid/rdata at M+1, mem_req low at M+1, new request sampled at M+1.
- Peak throughput one transaction per 2 cycles (mem_ready tied high).
- gnt and rvalid never high for both requesters in the same cycle.

## Configuration
- MEM_ARB_STARVE_GUARD_EN defined: counter increments on each ls grant while if_req=1; saturates at STARVE_MAX; when equal to STARVE_MAX next IDLE arbitration with if_req=1 grants fetch; counter clears on fetch grant or when if_req=0 in IDLE.
- Undefined: strict ls priority, no counter, fetch may starve; STARVE_MAX unused.

## Structure
- Shared package rv32_bus_pkg: arb_state_t enum (IDLE, BUSY_IF, BUSY_LS), default ADDR_W/DATA_W constants, requester id typedef.
- One sub-module: rv32_arb_starve_cnt (saturating counter, instantiated only under MEM_ARB_STARVE_GUARD_EN).

## Test plan
- Single fetch, if_addr=0x0000_0010, mem_ready=1, mem_rdata=0x0000_0013 -> if_gnt at N+1, if_rvalid with if_rdata=0x13 at N+2, mem_be=0xF, mem_we=0.
- Store ls_addr=0x8000_0000, ls_be=0x1, ls_wdata=0xA5, mem_ready delayed 3 cycles -> mem fields stable 4 cycles, ls_rvalid one cycle after ready, ls_rdata=0.
- if_req and ls_req both high same cycle -> ls_gnt first; if_gnt on next IDLE arbitration.
- ls_req held high continuously, if_req high, guard enabled STARVE_MAX=4 -> exactly 4 ls grants then 1 if grant, repeating; guard disabled -> if_gnt never asserts.
- rst pulsed in BUSY_LS with mem_ready=0 -> all outputs 0 next cycle, no ls_rvalid; reissued ls_req served normally.
- mem_ready toggling while IDLE with no requests -> no gnt/rvalid, mem_req stays 0.
